// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter. Sends one byte per valid/ready handshake,
// LSB first, with one start bit and one stop bit, each CYCLE clocks long.
//
// Ports:
//   clk           - clock
//   rst_n         - asynchronous active-low reset
//   tx_data       - byte to send, latched on handshake
//   tx_data_valid - upstream has a byte
//   tx_data_ready - transmitter can accept a byte (registered)
//   tx_pin        - serial line, idle high (registered)
module uart_tx #(
  parameter int unsigned CLK_FRE   = 27,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin
);

  localparam int unsigned CYCLE      = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_SEND_BYTE = 2'd2;
  localparam logic [1:0] S_STOP      = 2'd3;

  // Reject bit periods the 16-bit cycle counter cannot represent.
  if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
    $error("uart_tx: CLK_FRE/BAUD_RATE gives CYCLE outside 2..65535");
  end

  logic [1:0]  r_state;
  logic [15:0] r_cycle_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_data;
  logic        r_tx_pin;
  logic        r_tx_data_ready;

  logic [1:0]  w_state_nxt;
  logic [15:0] w_cycle_cnt_nxt;
  logic [2:0]  w_bit_cnt_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_tx_pin_nxt;
  logic        w_ready_nxt;
  logic        w_bit_end;
  logic [2:0]  w_bit_inc;

  assign w_bit_end = (r_cycle_cnt == CYCLE_LAST);
  assign w_bit_inc = r_bit_cnt + 3'd1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cycle_cnt     <= 16'd0;
      r_bit_cnt       <= 3'd0;
      r_data          <= 8'd0;
      r_tx_pin        <= 1'b1;
      r_tx_data_ready <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_cycle_cnt     <= w_cycle_cnt_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_data          <= w_data_nxt;
      r_tx_pin        <= w_tx_pin_nxt;
      r_tx_data_ready <= w_ready_nxt;
    end
  end

  // Next-state, counters and next line level; the line level is computed one
  // edge ahead so every output comes straight from a flop.
  always_comb begin
    w_state_nxt     = r_state;
    w_cycle_cnt_nxt = r_cycle_cnt + 16'd1;
    w_bit_cnt_nxt   = 3'd0;
    w_data_nxt      = r_data;
    w_tx_pin_nxt    = r_tx_pin;
    w_ready_nxt     = r_tx_data_ready;

    case (r_state)
      S_IDLE: begin
        w_tx_pin_nxt = 1'b1;
        w_ready_nxt  = 1'b1;
        if (tx_data_valid && r_tx_data_ready) begin
          w_state_nxt     = S_START;
          w_data_nxt      = tx_data;
          w_ready_nxt     = 1'b0;
          w_tx_pin_nxt    = 1'b0;
          w_cycle_cnt_nxt = 16'd0;
        end
      end

      S_START: begin
        w_tx_pin_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt     = S_SEND_BYTE;
          w_cycle_cnt_nxt = 16'd0;
          w_tx_pin_nxt    = r_data[0];
        end
      end

      S_SEND_BYTE: begin
        w_bit_cnt_nxt = r_bit_cnt;
        if (w_bit_end) begin
          w_cycle_cnt_nxt = 16'd0;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt   = S_STOP;
            w_bit_cnt_nxt = 3'd0;
            w_tx_pin_nxt  = 1'b1;
          end else begin
            w_bit_cnt_nxt = w_bit_inc;
            w_tx_pin_nxt  = r_data[w_bit_inc];
          end
        end
      end

      S_STOP: begin
        w_tx_pin_nxt = 1'b1;
        if (w_bit_end) begin
          w_state_nxt     = S_IDLE;
          w_cycle_cnt_nxt = 16'd0;
          w_ready_nxt     = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_cycle_cnt_nxt = 16'd0;
        w_tx_pin_nxt    = 1'b1;
        w_ready_nxt     = 1'b1;
      end
    endcase
  end

  assign tx_pin        = r_tx_pin;
  assign tx_data_ready = r_tx_data_ready;

endmodule
